// File: rtl/riscV_unrn_pkg.sv
// Shared memory-access types for the unicycle core and its bus-side adapters.
package riscV_unrn_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'b0000,
    MEM_SB  = 4'b0001,
    MEM_SH  = 4'b0010,
    MEM_SW  = 4'b0011,
    MEM_LB  = 4'b1001,
    MEM_LH  = 4'b1010,
    MEM_LW  = 4'b1011,
    MEM_LBU = 4'b1100,
    MEM_LHU = 4'b1101
  } mem_inst_type_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_bus_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_t;

  function automatic logic is_load(input mem_inst_type_t t);
    return t[3];
  endfunction

  function automatic logic is_store(input mem_inst_type_t t);
    return !t[3] && (t != MEM_NOP);
  endfunction

  function automatic access_size_t access_size(input mem_inst_type_t t);
    case (t)
      MEM_SB, MEM_LB, MEM_LBU: return SZ_BYTE;
      MEM_SH, MEM_LH, MEM_LHU: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input mem_inst_type_t t, input logic [1:0] offset);
    case (access_size(t))
      SZ_WORD: return offset == 2'b00;
      SZ_HALF: return !offset[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and replicated write data toward the bus,
// lane extraction and sign/zero extension of read data back to the core.
module mem_lane_align
  import riscV_unrn_pkg::*;
(
  input  mem_inst_type_t instType,
  input  logic [1:0]     offset,
  input  logic [31:0]    wdata,
  input  logic [31:0]    rdata,
  output logic [3:0]     be,
  output logic [31:0]    busWdata,
  output logic [31:0]    rdataExt
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    be       = '0;
    busWdata = '0;
    rdataExt = '0;
    case (access_size(instType))
      SZ_BYTE: begin
        be       = 4'b0001 << offset;
        busWdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be       = offset[1] ? 4'b1100 : 4'b0011;
        busWdata = {2{wdata[15:0]}};
      end
      default: begin
        be       = '1;
        busWdata = wdata;
      end
    endcase
    case (instType)
      MEM_LB:  rdataExt = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: rdataExt = {24'h000000, shifted[7:0]};
      MEM_LH:  rdataExt = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: rdataExt = {16'h0000, shifted[15:0]};
      default: rdataExt = shifted;
    endcase
  end

endmodule

// File: rtl/mem_bus_adapter.sv
// Turns unicycle core memory accesses into word-aligned req/gnt + rvalid bus
// transactions, stalling the core while a transaction is outstanding.
module mem_bus_adapter
  import riscV_unrn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  mem_inst_type_t inst_type_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    rdata_o,
  output logic           stall_o,
  output logic           misaligned_o,
  output logic           bus_err_o,
  output logic           bus_req_o,
  output logic           bus_we_o,
  output logic [31:0]    bus_addr_o,
  output logic [3:0]     bus_be_o,
  output logic [31:0]    bus_wdata_o,
  input  logic           bus_gnt_i,
  input  logic           bus_rvalid_i,
  input  logic [31:0]    bus_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_bus_state_t state;
  mem_inst_type_t reqType, lastType, alignType;
  logic [31:0]    reqAddr, lastAddr;
  logic           lastValid;
  logic [CNT_W-1:0] timeoutCnt;
  logic           newReq, aligned, timeoutHit;
  logic [1:0]     alignOffset;
  logic [3:0]     laneBe;
  logic [31:0]    laneWdata, laneRdata;

  // The lane unit sees the live request in IDLE (to build be/wdata) and the
  // latched request otherwise (to extract the returning read word).
  always_comb begin
    newReq      = (inst_type_i != MEM_NOP) &&
                  (!lastValid || (inst_type_i != lastType) || (addr_i != lastAddr));
    aligned     = is_aligned(inst_type_i, addr_i[1:0]);
    stall_o     = ((state == IDLE) && newReq && aligned) || (state != IDLE);
    timeoutHit  = timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1);
    alignType   = (state == IDLE) ? inst_type_i : reqType;
    alignOffset = (state == IDLE) ? addr_i[1:0] : reqAddr[1:0];
  end

  mem_lane_align u_lane (
    .instType (alignType),
    .offset   (alignOffset),
    .wdata    (wdata_i),
    .rdata    (bus_rdata_i),
    .be       (laneBe),
    .busWdata (laneWdata),
    .rdataExt (laneRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rdata_o      <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
      reqType      <= MEM_NOP;
      reqAddr      <= '0;
      lastType     <= MEM_NOP;
      lastAddr     <= '0;
      lastValid    <= 1'b0;
      timeoutCnt   <= '0;
    end else begin
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      if (inst_type_i == MEM_NOP) lastValid <= 1'b0;
      case (state)
        IDLE: begin
          timeoutCnt <= '0;
          if (newReq && !aligned) begin
            misaligned_o <= 1'b1;
            lastType     <= inst_type_i;
            lastAddr     <= addr_i;
            lastValid    <= 1'b1;
          end else if (newReq) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store(inst_type_i);
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= laneBe;
            bus_wdata_o <= laneWdata;
            reqType     <= inst_type_i;
            reqAddr     <= addr_i;
            state       <= REQ;
          end
        end
        // A load granted on the last allowed cycle still aborts, so the
        // counter never runs past its terminal value in WAIT.
        REQ: begin
          if (bus_gnt_i && is_store(reqType)) begin
            bus_req_o <= 1'b0;
            lastType  <= reqType;
            lastAddr  <= reqAddr;
            lastValid <= 1'b1;
            state     <= IDLE;
          end else if (timeoutHit) begin
            bus_err_o <= 1'b1;
            rdata_o   <= '0;
            bus_req_o <= 1'b0;
            lastType  <= reqType;
            lastAddr  <= reqAddr;
            lastValid <= 1'b1;
            state     <= IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
            if (bus_gnt_i) begin
              bus_req_o <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            rdata_o   <= laneRdata;
            lastType  <= reqType;
            lastAddr  <= reqAddr;
            lastValid <= 1'b1;
            state     <= IDLE;
          end else if (timeoutHit) begin
            bus_err_o <= 1'b1;
            rdata_o   <= '0;
            lastType  <= reqType;
            lastAddr  <= reqAddr;
            lastValid <= 1'b1;
            state     <= IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reqHeldWhileStalled: assert property (
    @(posedge clk) disable iff (rst)
    (state != IDLE) |-> ((inst_type_i == reqType) && (addr_i == reqAddr))
  );

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Directed, table-driven bench for mem_bus_adapter with hand-computed results
// plus multi-cycle sequences for repeat suppression, gnt delay, timeout, reset.
module tb_mem_bus_adapter;
  import riscV_unrn_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  mem_inst_type_t instType;
  logic [31:0]    addr, wdata, rdataOut, busAddr, busWdata, busRdata;
  logic           stall, misaligned, busErr, busReq, busWe, busGnt, busRvalid;
  logic [3:0]     busBe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_type_i  (instType),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdataOut),
    .stall_o      (stall),
    .misaligned_o (misaligned),
    .bus_err_o    (busErr),
    .bus_req_o    (busReq),
    .bus_we_o     (busWe),
    .bus_addr_o   (busAddr),
    .bus_be_o     (busBe),
    .bus_wdata_o  (busWdata),
    .bus_gnt_i    (busGnt),
    .bus_rvalid_i (busRvalid),
    .bus_rdata_i  (busRdata)
  );

  typedef struct {
    mem_inst_type_t t;
    logic [31:0]    a;
    logic [31:0]    wd;
    logic [31:0]    rd;
    logic           mis;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    bw;
    logic [31:0]    exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int reqCount;

    vecs[0]  = '{MEM_LW,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    vecs[1]  = '{MEM_LB,  32'h0000_0103, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{MEM_LBU, 32'h0000_0103, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
    vecs[3]  = '{MEM_LH,  32'h0000_0102, 32'h0, 32'h8001_1234, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001};
    vecs[4]  = '{MEM_LHU, 32'h0000_0100, 32'h0, 32'h8001_F234, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0000_F234};
    vecs[5]  = '{MEM_LB,  32'h0000_0101, 32'h0, 32'h1122_7F44, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h0000_007F};
    vecs[6]  = '{MEM_SB,  32'h0000_0202, 32'h0000_00A5, 32'h0, 1'b0, 1'b1, 4'b0100, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{MEM_SW,  32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{MEM_SH,  32'h0000_0100, 32'h1234_ABCD, 32'h0, 1'b0, 1'b1, 4'b0011, 32'hABCD_ABCD, 32'h0};
    vecs[9]  = '{MEM_LW,  32'h0000_0101, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0};
    vecs[10] = '{MEM_SH,  32'h0000_0103, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{MEM_LHU, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0000_BEEF};
    vecs[12] = '{MEM_SW,  32'h0000_0302, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0};
    vecs[13] = '{MEM_LH,  32'h0000_0100, 32'h0, 32'h0000_FFFE, 1'b0, 1'b0, 4'b0011, 32'h0, 32'hFFFF_FFFE};
    vecs[14] = '{MEM_LB,  32'h0000_0102, 32'h0, 32'h0055_0000, 1'b0, 1'b0, 4'b0100, 32'h0, 32'h0000_0055};

    rst = 1'b1; instType = MEM_NOP; addr = '0; wdata = '0;
    busGnt = 1'b0; busRvalid = 1'b0; busRdata = '0;
    repeat (3) toNext();
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_rdata", rdataOut, 0);
    check("rst_req", busReq, 0);
    check("rst_mis", misaligned, 0);
    check("rst_err", busErr, 0);
    check("rst_we", busWe, 0);
    check("rst_addr", busAddr, 0);
    check("rst_be", busBe, 0);
    check("rst_wdata", busWdata, 0);
    toNext();

    // Single-access vectors: gnt on the first REQ cycle, rvalid right after.
    for (int i = 0; i < NVEC; i++) begin
      v = vecs[i];
      instType = MEM_NOP; busGnt = 1'b0; busRvalid = 1'b0;
      toNext();
      instType = v.t; addr = v.a; wdata = v.wd;
      @(negedge clk);
      check($sformatf("v%0d_stall_issue", i), stall, !v.mis);
      toNext();
      if (v.mis) begin
        @(negedge clk);
        check($sformatf("v%0d_mis_pulse", i), misaligned, 1);
        check($sformatf("v%0d_mis_req", i), busReq, 0);
        check($sformatf("v%0d_mis_stall", i), stall, 0);
        toNext();
        @(negedge clk);
        check($sformatf("v%0d_mis_end", i), misaligned, 0);
        check($sformatf("v%0d_mis_req2", i), busReq, 0);
        toNext();
      end else begin
        busGnt = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_req", i), busReq, 1);
        check($sformatf("v%0d_stall_req", i), stall, 1);
        check($sformatf("v%0d_we", i), busWe, v.we);
        check($sformatf("v%0d_addr", i), busAddr, v.a & 32'hFFFF_FFFC);
        check($sformatf("v%0d_be", i), busBe, v.be);
        check($sformatf("v%0d_wdata", i), busWdata, v.bw);
        toNext();
        busGnt = 1'b0;
        if (!v.we) begin
          busRvalid = 1'b1; busRdata = v.rd;
          @(negedge clk);
          check($sformatf("v%0d_req_wait", i), busReq, 0);
          check($sformatf("v%0d_stall_wait", i), stall, 1);
          toNext();
          busRvalid = 1'b0;
        end
        @(negedge clk);
        check($sformatf("v%0d_stall_done", i), stall, 0);
        check($sformatf("v%0d_req_done", i), busReq, 0);
        if (!v.we) check($sformatf("v%0d_rdata", i), rdataOut, v.exp);
        toNext();
      end
    end

    // Core holds MEM_LW for six cycles; only the first presentation goes out,
    // and a stray rvalid in IDLE must not disturb the held data.
    instType = MEM_NOP; toNext();
    reqCount = 0;
    for (int c = 0; c < 6; c++) begin
      instType = MEM_LW; addr = 32'h8000_0004;
      busGnt = (c == 1);
      busRvalid = (c == 2) || (c == 4);
      busRdata = (c == 2) ? 32'hDEAD_BEEF : 32'h1111_1111;
      @(negedge clk);
      if (busReq) reqCount++;
      check($sformatf("rep_stall_c%0d", c), stall, (c < 3) ? 1 : 0);
      toNext();
    end
    busGnt = 1'b0; busRvalid = 1'b0;
    @(negedge clk);
    check("rep_req_count", reqCount, 1);
    check("rep_rdata", rdataOut, 32'hDEAD_BEEF);
    toNext();

    // SH with gnt three cycles late (plus an ignored gnt while still IDLE).
    instType = MEM_NOP; toNext();
    reqCount = 0;
    for (int c = 0; c < 6; c++) begin
      instType = MEM_SH; addr = 32'h0000_0102; wdata = 32'h1234_ABCD;
      busGnt = (c == 0) || (c == 4);
      @(negedge clk);
      if (busReq) reqCount++;
      if (c == 1) begin
        check("sh_be", busBe, 4'b1100);
        check("sh_wdata", busWdata, 32'hABCD_ABCD);
        check("sh_we", busWe, 1);
      end
      check($sformatf("sh_stall_c%0d", c), stall, (c < 5) ? 1 : 0);
      toNext();
    end
    busGnt = 1'b0;
    check("sh_req_count", reqCount, 4);
    check("sh_rdata_held", rdataOut, 32'hDEAD_BEEF);

    // Load that never sees rvalid: abort eight cycles after entering REQ.
    instType = MEM_NOP; toNext();
    reqCount = 0;
    for (int c = 0; c < 11; c++) begin
      instType = MEM_LW; addr = 32'h0000_0400;
      busGnt = (c == 1);
      @(negedge clk);
      if (busReq) reqCount++;
      check($sformatf("to_err_c%0d", c), busErr, (c == 9) ? 1 : 0);
      if (c == 8) check("to_rdata_before", rdataOut, 32'hDEAD_BEEF);
      if (c >= 9) begin
        check($sformatf("to_rdata_c%0d", c), rdataOut, 0);
        check($sformatf("to_stall_c%0d", c), stall, 0);
        check($sformatf("to_req_c%0d", c), busReq, 0);
      end
      toNext();
    end
    busGnt = 1'b0;
    check("to_req_count", reqCount, 1);

    // Reset while waiting for read data; the late rvalid must be ignored.
    instType = MEM_NOP; toNext();
    instType = MEM_LW; addr = 32'h0000_0500;
    toNext();
    busGnt = 1'b1;
    toNext();
    busGnt = 1'b0;
    rst = 1'b1; instType = MEM_NOP;
    @(negedge clk);
    check("rstw_stall_wait", stall, 1);
    toNext();
    rst = 1'b0; busRvalid = 1'b1; busRdata = 32'h1234_5678;
    @(negedge clk);
    check("rstw_req", busReq, 0);
    check("rstw_stall", stall, 0);
    toNext();
    busRvalid = 1'b0;
    @(negedge clk);
    check("rstw_rdata", rdataOut, 0);
    check("rstw_stall2", stall, 0);
    check("rstw_req2", busReq, 0);
    toNext();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
